// File: rtl/maclaurin_job_sequencer_if.sv
// Signal bundle between the host, the job sequencer and the Maclaurin calculator.
// The slave modport is the sequencer; the master modport is its environment.
interface maclaurin_job_sequencer_if;
  logic        reqValid;
  logic        reqReady;
  logic [15:0] reqX;
  logic [1:0]  reqFunc;
  logic        calcStart;
  logic [15:0] calcX;
  logic [1:0]  calcFunc;
  logic        calcRst;
  logic        calcDone;
  logic [17:0] calcR;
  logic        rspValid;
  logic        rspReady;
  logic [17:0] rspR;
  logic [1:0]  rspFunc;
  logic        rspTimeout;
  logic        busy;

  modport slave (
    input  reqValid, reqX, reqFunc, calcDone, calcR, rspReady,
    output reqReady, calcStart, calcX, calcFunc, calcRst,
           rspValid, rspR, rspFunc, rspTimeout, busy
  );

  modport master (
    output reqValid, reqX, reqFunc, calcDone, calcR, rspReady,
    input  reqReady, calcStart, calcX, calcFunc, calcRst,
           rspValid, rspR, rspFunc, rspTimeout, busy
  );
endinterface

// File: rtl/maclaurin_job_sequencer.sv
// Buffers (x, func) jobs, runs them one at a time on the Maclaurin calculator
// under a watchdog, and returns each result tagged with func and a timeout flag.
module maclaurin_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  maclaurin_job_sequencer_if.slave  bus
);

  localparam int              AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int              CW        = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C   = CW'(DEPTH);
  localparam logic [15:0]     TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        next_state_s;
  logic [15:0]   fifo_x_r    [DEPTH];
  logic [1:0]    fifo_func_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [15:0]   wd_r;
  logic [15:0]   wd_inc_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          capture_s;
  logic          expire_s;
  logic [15:0]   calc_x_r;
  logic [1:0]    calc_func_r;
  logic          calc_start_r;
  logic          calc_rst_r;
  logic          rsp_valid_r;
  logic [17:0]   rsp_r_r;
  logic [1:0]    rsp_func_r;
  logic          rsp_timeout_r;

  assign full_s   = (count_r == DEPTH_C);
  assign empty_s  = (count_r == CW'(0));
  assign push_s   = bus.reqValid && !full_s;
  assign wd_inc_s = wd_r + 16'd1;

  // Next-state logic: pop decision, result capture and watchdog expiry
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    capture_s    = 1'b0;
    expire_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s        = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        next_state_s = WAIT;
      end
      WAIT: begin
        // wd_r == 0 is the guard cycle: a Done still high from the previous job is ignored
        if ((wd_r != 16'd0) && bus.calcDone) begin
          capture_s    = 1'b1;
          next_state_s = HOLD;
        end else if (wd_inc_s == TIMEOUT_C) begin
          expire_s     = 1'b1;
          next_state_s = HOLD;
        end else begin
          next_state_s = WAIT;
        end
      end
      HOLD: begin
        if (bus.rspReady) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = HOLD;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage; entries are only read while counted, so they need no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_x_r[wr_ptr_r]    <= bus.reqX;
      fifo_func_r[wr_ptr_r] <= bus.reqFunc;
    end
  end

  // Watchdog: cleared while issuing, counts every WAIT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_r <= 16'd0;
    end else if (state_r == ISSUE) begin
      wd_r <= 16'd0;
    end else if (state_r == WAIT) begin
      wd_r <= wd_inc_s;
    end else begin
      wd_r <= wd_r;
    end
  end

  // Calculator operands, changed only when a job is popped
  always_ff @(posedge clk) begin
    if (rst) begin
      calc_x_r    <= 16'd0;
      calc_func_r <= 2'd0;
    end else if (pop_s) begin
      calc_x_r    <= fifo_x_r[rd_ptr_r];
      calc_func_r <= fifo_func_r[rd_ptr_r];
    end
  end

  // Registered control pulses and response-valid level
  always_ff @(posedge clk) begin
    if (rst) begin
      calc_start_r <= 1'b0;
      calc_rst_r   <= 1'b0;
      rsp_valid_r  <= 1'b0;
    end else begin
      calc_start_r <= (next_state_s == ISSUE);
      calc_rst_r   <= expire_s;
      rsp_valid_r  <= (next_state_s == HOLD);
    end
  end

  // Response payload, frozen from capture or expiry until the next job completes
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_r_r       <= 18'd0;
      rsp_func_r    <= 2'd0;
      rsp_timeout_r <= 1'b0;
    end else if (capture_s) begin
      rsp_r_r       <= bus.calcR;
      rsp_func_r    <= calc_func_r;
      rsp_timeout_r <= 1'b0;
    end else if (expire_s) begin
      rsp_r_r       <= 18'd0;
      rsp_func_r    <= calc_func_r;
      rsp_timeout_r <= 1'b1;
    end
  end

  // Every output is forced low while rst is high, including the cycle rst is first sampled
  assign bus.reqReady   = !rst && !full_s;
  assign bus.calcStart  = !rst && calc_start_r;
  assign bus.calcX      = rst ? 16'd0 : calc_x_r;
  assign bus.calcFunc   = rst ? 2'd0 : calc_func_r;
  assign bus.calcRst    = !rst && calc_rst_r;
  assign bus.rspValid   = !rst && rsp_valid_r;
  assign bus.rspR       = rst ? 18'd0 : rsp_r_r;
  assign bus.rspFunc    = rst ? 2'd0 : rsp_func_r;
  assign bus.rspTimeout = !rst && rsp_timeout_r;
  assign bus.busy       = !rst && ((state_r != IDLE) || !empty_s);

endmodule

// File: tb/tb_maclaurin_job_sequencer.sv
// Randomized scoreboard bench for maclaurin_job_sequencer with a behavioural calculator stub.
// Each accepted job is planned (latency, stale Done, result) and its response is predicted from those rules.
module tb_maclaurin_job_sequencer;
  localparam int DEPTH = 4;
  localparam int TO    = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maclaurin_job_sequencer_if bus();

  maclaurin_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] x;
    logic [1:0]  func;
    int          lat;    // cycles from start to Done; 0 = never
    bit          stale;  // Done held high during the start and guard cycles
    logic [17:0] val;
  } job_t;

  typedef struct {
    logic [17:0] r;
    logic [1:0]  func;
    bit          to;
  } rsp_t;

  job_t plan_q[$];
  rsp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int last_accept_cyc = 0;
  int last_start_cyc = 0;
  int last_hs_cyc = -1000;
  int start_gap = 0;
  bit rst_seen = 1'b0;
  bit rand_done = 1'b0;

  // stub state
  job_t st_cur;
  int   st_k = 0;
  int   st_start = 0;
  bit   st_open = 1'b0;
  bit   st_pend = 1'b0;

  // monitor state
  bit          m_pv = 1'b0;
  bit          m_pr = 1'b0;
  bit          m_pd = 1'b0;
  bit          m_ps = 1'b0;
  bit          m_out = 1'b0;
  logic [17:0] m_r = 18'd0;
  logic [1:0]  m_f = 2'd0;
  bit          m_t = 1'b0;
  rsp_t        m_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // A result is captured only if Done arrives after the guard cycle and within TO WAIT cycles
  function automatic rsp_t model(input job_t j);
    rsp_t e;
    e.func = j.func;
    e.to   = (j.lat < 2) || (j.lat > TO);
    e.r    = e.to ? 18'd0 : j.val;
    return e;
  endfunction

  function automatic job_t mk(input logic [1:0] f, input int lat, input bit stale);
    job_t j;
    j.x     = 16'($urandom);
    j.func  = f;
    j.lat   = lat;
    j.stale = stale;
    j.val   = 18'($urandom);
    return j;
  endfunction

  function automatic job_t rand_job();
    int sel;
    int lat;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       lat = 0;
      1:       lat = 1;
      2:       lat = TO;
      3:       lat = TO + 1;
      default: lat = $urandom_range(2, 12);
    endcase
    return mk(2'($urandom), lat, (lat != 1) && ($urandom_range(0, 3) == 0));
  endfunction

  task automatic push(input job_t j);
    int n;
    n = 0;
    @(posedge clk); #1;
    bus.reqValid = 1'b1;
    bus.reqX     = j.x;
    bus.reqFunc  = j.func;
    while (1) begin
      @(negedge clk);
      if (bus.reqReady) begin
        plan_q.push_back(j);
        exp_q.push_back(model(j));
        accepted++;
        last_accept_cyc = cyc;
        break;
      end
      n++;
      if (n >= 2000) begin
        check("push_accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    bus.reqValid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < 3000), 64'd1);
  endtask

  // Calculator stub: acts #2 after each rising edge, plays back the plan of the issued job
  initial begin
    bus.calcDone = 1'b0;
    bus.calcR    = 18'd0;
    forever begin
      @(posedge clk); #2;
      bus.calcDone = 1'b0;
      if (rst) begin
        st_open = 1'b0;
        st_pend = 1'b0;
      end else begin
        if (bus.calcRst) begin
          check("calcrst_latency", 64'(cyc - st_start), 64'(TO + 1));
          rst_seen = 1'b1;
          st_open  = 1'b0;
          st_pend  = 1'b0;
        end
        if (bus.calcStart) begin
          if (plan_q.size() == 0) begin
            check("start_without_job", 64'd1, 64'd0);
            st_open = 1'b0;
            st_pend = 1'b0;
          end else begin
            st_cur   = plan_q.pop_front();
            st_start = cyc;
            st_k     = 0;
            st_open  = 1'b1;
            st_pend  = (st_cur.lat != 0);
          end
        end else if (st_open) begin
          st_k++;
        end
        if (st_open) begin
          check("calc_operand", {bus.calcX, bus.calcFunc}, {st_cur.x, st_cur.func});
          if (st_cur.stale && st_k <= 1) begin
            bus.calcDone = 1'b1;
            bus.calcR    = ~st_cur.val;
          end
        end
        if (st_pend && st_k == st_cur.lat) begin
          bus.calcDone = 1'b1;
          bus.calcR    = st_cur.val;
          st_pend      = 1'b0;
        end
      end
    end
  end

  // Monitor: samples on the falling edge and scores every response handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs",
              64'({bus.reqReady, bus.calcStart, bus.calcX, bus.calcFunc, bus.calcRst,
                   bus.rspValid, bus.rspR, bus.rspFunc, bus.rspTimeout, bus.busy}), 64'd0);
        m_out = 1'b0; m_pv = 1'b0; m_pr = 1'b0; m_ps = 1'b0; m_pd = 1'b0;
        last_hs_cyc = -1000;
        rst_seen = 1'b0;
      end else begin
        if (bus.calcStart) begin
          check("start_pulse_width", 64'(m_ps), 64'd0);
          check("one_outstanding", 64'(m_out), 64'd0);
          m_out = 1'b1;
          last_start_cyc = cyc;
          start_gap = cyc - last_hs_cyc;
          check("restart_gap", 64'(start_gap >= 2), 64'd1);
        end
        if (bus.rspValid && !m_pv && !bus.rspTimeout) begin
          check("done_to_valid", 64'(m_pd), 64'd1);
        end
        if (m_pv && !m_pr) begin
          check("rsp_hold", {bus.rspValid, bus.rspR, bus.rspFunc, bus.rspTimeout},
                {1'b1, m_r, m_f, m_t});
        end
        if (bus.rspValid && bus.rspReady) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 64'd1, 64'd0);
          end else begin
            m_e = exp_q.pop_front();
            check("rsp", {bus.rspR, bus.rspFunc, bus.rspTimeout}, {m_e.r, m_e.func, m_e.to});
            check("calcrst_seen", 64'(rst_seen), 64'(m_e.to));
          end
          rst_seen = 1'b0;
          m_out = 1'b0;
          last_hs_cyc = cyc;
        end
        m_pv = bus.rspValid;
        m_pr = bus.rspReady;
        m_pd = bus.calcDone;
        m_ps = bus.calcStart;
        m_r  = bus.rspR;
        m_f  = bus.rspFunc;
        m_t  = bus.rspTimeout;
      end
    end
  end

  initial begin
    job_t j;
    int   base;
    int   n;
    bus.reqValid = 1'b0;
    bus.reqX     = 16'd0;
    bus.reqFunc  = 2'd0;
    bus.rspReady = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single job with a known result
    j = mk(2'd0, 20, 1'b0);
    j.x   = 16'h4000;
    j.val = 18'h148B5;
    push(j);
    drain("t1_drain");
    check("t1_issue_latency", 64'(last_start_cyc - last_accept_cyc), 64'd2);

    // fill the FIFO behind a stalled response
    @(posedge clk); #1 bus.rspReady = 1'b0;
    base = accepted;
    fork
      begin
        for (int i = 0; i < 6; i++) push(mk(2'(i), 4, 1'b0));
      end
      begin
        repeat (40) @(negedge clk);
        check("t2_reqready_full", 64'(bus.reqReady), 64'd0);
        check("t2_accepted", 64'(accepted - base), 64'(DEPTH + 1));
        @(posedge clk); #1 bus.rspReady = 1'b1;
      end
    join
    drain("t2_drain");

    // stale Done over start and guard cycles
    push(mk(2'd1, 6, 1'b1));
    push(mk(2'd2, 2, 1'b1));
    drain("t3_drain");

    // watchdog: never, normal, capture at the limit, guard-only Done, one past the limit
    push(mk(2'd0, 0, 1'b0));
    push(mk(2'd3, 5, 1'b0));
    push(mk(2'd1, TO, 1'b0));
    push(mk(2'd2, 1, 1'b0));
    push(mk(2'd0, TO + 1, 1'b0));
    drain("t4_drain");

    // response backpressure for 10 cycles with a job waiting behind it
    @(posedge clk); #1 bus.rspReady = 1'b0;
    push(mk(2'd1, 3, 1'b0));
    push(mk(2'd2, 3, 1'b0));
    n = 0;
    while (!bus.rspValid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_valid_seen", 64'(n < 200), 64'd1);
    repeat (10) @(negedge clk);
    check("t5_still_valid", 64'(bus.rspValid), 64'd1);
    @(posedge clk); #1 bus.rspReady = 1'b1;
    drain("t5_drain");
    check("t5_restart_gap", 64'(start_gap), 64'd2);

    // reset while one job waits on the calculator and two are queued
    push(mk(2'd0, 0, 1'b0));
    push(mk(2'd1, 0, 1'b0));
    push(mk(2'd2, 0, 1'b0));
    repeat (4) @(negedge clk);
    check("t6_busy_before_rst", 64'(bus.busy), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    plan_q.delete();
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_reqready_after_rst", 64'(bus.reqReady), 64'd1);
    check("t6_idle_after_rst", 64'(bus.busy), 64'd0);
    repeat (10) @(negedge clk);
    push(mk(2'd3, 7, 1'b0));
    drain("t6_drain");
    check("t6_issue_latency", 64'(last_start_cyc - last_accept_cyc), 64'd2);

    // random jobs against random response backpressure
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          push(rand_job());
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          bus.rspReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1 bus.rspReady = 1'b1;
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
